// File: rtl/rega_pkg.sv
// Shared definitions for the BCD counter and its 7-segment display decoders.
//   - BCD_MAX        : highest legal BCD digit value
//   - seg_bit_e      : bit positions inside an 8-bit segment bus {dp,g,f,e,d,c,b,a}
//   - SEG_0..SEG_9   : digit glyphs, active-high form (1 = segment lit)
//   - SEG_OFF        : all segments dark, active-high form
//   - bcd2_t         : two-digit BCD value {tens, units}
package rega_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Segment bus bit order: bit 0 is segment a, bit 7 is the decimal point.
  typedef enum logic [2:0] {
    SEG_A  = 3'd0,
    SEG_B  = 3'd1,
    SEG_C  = 3'd2,
    SEG_D  = 3'd3,
    SEG_E  = 3'd4,
    SEG_F  = 3'd5,
    SEG_G  = 3'd6,
    SEG_DP = 3'd7
  } seg_bit_e;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0   = 8'h3F;
  localparam seg_t SEG_1   = 8'h06;
  localparam seg_t SEG_2   = 8'h5B;
  localparam seg_t SEG_3   = 8'h4F;
  localparam seg_t SEG_4   = 8'h66;
  localparam seg_t SEG_5   = 8'h6D;
  localparam seg_t SEG_6   = 8'h7D;
  localparam seg_t SEG_7   = 8'h07;
  localparam seg_t SEG_8   = 8'h7F;
  localparam seg_t SEG_9   = 8'h6F;
  localparam seg_t SEG_OFF = 8'h00;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

endpackage

// File: rtl/bcd_7seg.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i  in  4  BCD digit (0..9; anything above 9 blanks the display)
//   seg_o  out 8  segments {dp,g,f,e,d,c,b,a}; polarity set by SEG_ACT_LOW
// The decimal point is never lit.
module bcd_7seg
  import rega_pkg::*;
#(
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  seg_t seg_hi;

  // NOTE: a default before the case means every path assigns seg_hi, so no latch is inferred.
  always_comb begin
    seg_hi = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_hi = SEG_0;
      4'd1:    seg_hi = SEG_1;
      4'd2:    seg_hi = SEG_2;
      4'd3:    seg_hi = SEG_3;
      4'd4:    seg_hi = SEG_4;
      4'd5:    seg_hi = SEG_5;
      4'd6:    seg_hi = SEG_6;
      4'd7:    seg_hi = SEG_7;
      4'd8:    seg_hi = SEG_8;
      4'd9:    seg_hi = SEG_9;
      default: seg_hi = SEG_OFF;
    endcase
  end

  assign seg_o = SEG_ACT_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/cont_cres.sv
// Two-digit BCD up counter with programmable limit and 7-segment outputs.
//   Clk    in   1  system clock, rising edge
//   Rst_n  in   1  asynchronous reset, active-low
//   En     in   1  count enable (one-cycle time-base tick)
//   Clr    in   1  synchronous clear to 00 (wins over En)
//   Lim    in   8  BCD limit {tens, units}
//   Q      out  8  BCD count {tens, units}
//   Tc     out  1  Q == {MAX_TENS,9} while En is high (combinational)
//   Done   out  1  registered: count equals a valid Lim
//   M7_U   out  8  units digit segments {dp,g,f,e,d,c,b,a}
//   M7_D   out  8  tens digit segments {dp,g,f,e,d,c,b,a}
// With HOLD_AT_LIM set, the count freezes while Done is high; Clr or a
// Lim change that clears Done releases it.
module cont_cres
  import rega_pkg::*;
#(
  parameter int unsigned MAX_TENS    = 9,
  parameter bit          HOLD_AT_LIM = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic       Clr,
  input  logic [7:0] Lim,
  output logic [7:0] Q,
  output logic       Tc,
  output logic       Done,
  output logic [7:0] M7_U,
  output logic [7:0] M7_D
);

  localparam logic [3:0] TENS_MAX = 4'(MAX_TENS);

  bcd2_t cnt_q, cnt_d;
  logic  done_q, done_d;
  logic  at_top;
  logic  advance;
  logic  lim_valid;
  bcd2_t lim_bcd;

  assign lim_bcd = bcd2_t'(Lim);
  assign at_top  = (cnt_q.tens == TENS_MAX) && (cnt_q.units == BCD_MAX);
  // A held count ignores the tick; Tc still reports the tick at the top value.
  assign advance = En && !(HOLD_AT_LIM && done_q);

  // An out-of-range limit can never be reached, so Done must stay low for it.
  assign lim_valid = (lim_bcd.units <= BCD_MAX) && (lim_bcd.tens <= BCD_MAX) &&
                     (lim_bcd.tens <= TENS_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (advance) begin
      if (cnt_q.units == BCD_MAX) begin
        cnt_d.units = 4'd0;
        cnt_d.tens  = (cnt_q.tens == TENS_MAX) ? 4'd0 : cnt_q.tens + 4'd1;
      end else begin
        cnt_d.units = cnt_q.units + 4'd1;
      end
    end
  end

  // Compare against the next count so Done rises together with Q reaching Lim.
  assign done_d = (cnt_d == lim_bcd) && lim_valid;

  // NOTE: state flops use non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Q    = cnt_q;
  assign Done = done_q;
  assign Tc   = at_top && En;

  bcd_7seg #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_seg_units (
    .bcd_i (cnt_q.units),
    .seg_o (M7_U)
  );

  bcd_7seg #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_seg_tens (
    .bcd_i (cnt_q.tens),
    .seg_o (M7_D)
  );

endmodule

// File: tb/tb_cont_cres.sv
// Self-checking bench for cont_cres.
//   dut_a : MAX_TENS=9, HOLD_AT_LIM=1, active-low segments
//   dut_b : MAX_TENS=5, HOLD_AT_LIM=1, active-low segments
//   dut_c : MAX_TENS=9, HOLD_AT_LIM=0, active-high segments
//   u_dec : standalone decoder, active-high
module tb_cont_cres;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] lim_a, lim_b, lim_c;
  logic [7:0] q_a, q_b, q_c;
  logic       tc_a, tc_b, tc_c;
  logic       done_a, done_b, done_c;
  logic [7:0] m7u_a, m7d_a, m7u_b, m7d_b, m7u_c, m7d_c;
  logic [3:0] dig_t;
  logic [7:0] seg_t_o;

  int n_checks = 0;
  int n_fail   = 0;

  cont_cres #(.MAX_TENS(9), .HOLD_AT_LIM(1'b1), .SEG_ACT_LOW(1'b1)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Clr(clr), .Lim(lim_a),
    .Q(q_a), .Tc(tc_a), .Done(done_a), .M7_U(m7u_a), .M7_D(m7d_a)
  );

  cont_cres #(.MAX_TENS(5), .HOLD_AT_LIM(1'b1), .SEG_ACT_LOW(1'b1)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Clr(clr), .Lim(lim_b),
    .Q(q_b), .Tc(tc_b), .Done(done_b), .M7_U(m7u_b), .M7_D(m7d_b)
  );

  cont_cres #(.MAX_TENS(9), .HOLD_AT_LIM(1'b0), .SEG_ACT_LOW(1'b0)) dut_c (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Clr(clr), .Lim(lim_c),
    .Q(q_c), .Tc(tc_c), .Done(done_c), .M7_U(m7u_c), .M7_D(m7d_c)
  );

  bcd_7seg #(.SEG_ACT_LOW(1'b0)) u_dec (
    .bcd_i (dig_t),
    .seg_o (seg_t_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  typedef struct {
    logic       clr;
    logic       en;
    logic [7:0] lim;
    logic [7:0] q;
    logic       done;
  } vec_t;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] seg;
  } seg_vec_t;

  vec_t     vecs[12];
  seg_vec_t segs[16];
  int       tc_seen;

  initial begin
    // Per-cycle vectors for dut_a, starting from Q=00 right after reset.
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1}; // Lim=00: Done on first edge
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1}; // frozen
    vecs[2]  = '{1'b0, 1'b1, 8'h03, 8'h00, 1'b0}; // still frozen this edge, Done drops
    vecs[3]  = '{1'b0, 1'b1, 8'h03, 8'h01, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h03, 8'h02, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h03, 8'h03, 1'b1}; // reaches limit
    vecs[6]  = '{1'b0, 1'b1, 8'h03, 8'h03, 1'b1}; // held
    vecs[7]  = '{1'b1, 1'b1, 8'h03, 8'h00, 1'b0}; // Clr releases
    vecs[8]  = '{1'b0, 1'b1, 8'h0A, 8'h01, 1'b0}; // invalid units digit
    vecs[9]  = '{1'b0, 1'b0, 8'h01, 8'h01, 1'b1}; // live Lim match without En
    vecs[10] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1}; // Clr with Lim=00
    vecs[11] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0}; // invalid limit

    segs[0]  = '{4'd0,  8'h3F};
    segs[1]  = '{4'd1,  8'h06};
    segs[2]  = '{4'd2,  8'h5B};
    segs[3]  = '{4'd3,  8'h4F};
    segs[4]  = '{4'd4,  8'h66};
    segs[5]  = '{4'd5,  8'h6D};
    segs[6]  = '{4'd6,  8'h7D};
    segs[7]  = '{4'd7,  8'h07};
    segs[8]  = '{4'd8,  8'h7F};
    segs[9]  = '{4'd9,  8'h6F};
    for (int i = 10; i < 16; i++) segs[i] = '{4'(i), 8'h00};

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    lim_a = 8'hFF;
    lim_b = 8'hFF;
    lim_c = 8'hFF;
    dig_t = 4'd0;
    #1;

    // Reset state
    check("rst_q",     q_a,    8'h00);
    check("rst_done",  done_a, 1'b0);
    check("rst_tc",    tc_a,   1'b0);
    check("rst_m7u",   m7u_a,  8'hC0);
    check("rst_m7d",   m7d_a,  8'hC0);
    check("rst_m7u_c", m7u_c,  8'h3F);

    // Decoder table
    for (int i = 0; i < 16; i++) begin
      dig_t = segs[i].dig;
      #1;
      check($sformatf("seg_dig%0d", i), seg_t_o, segs[i].seg);
    end

    #1;
    rst_n = 1'b1;

    // Cycle vectors on dut_a
    for (int i = 0; i < 12; i++) begin
      clr   = vecs[i].clr;
      en    = vecs[i].en;
      lim_a = vecs[i].lim;
      step();
      check($sformatf("vec%0d_q", i),    q_a,    vecs[i].q);
      check($sformatf("vec%0d_done", i), done_a, vecs[i].done);
    end

    // Full 00..99 sweep with invalid limit
    lim_a = 8'hFF;
    en    = 1'b0;
    clr   = 1'b1;
    step();
    clr = 1'b0;
    tc_seen = 0;
    for (int i = 0; i < 100; i++) begin
      en = 1'b1;
      #1;
      check($sformatf("sweep%0d_tc", i), tc_a, (i == 99));
      if (tc_a) tc_seen++;
      step();
      check($sformatf("sweep%0d_q", i),    q_a,    to_bcd((i + 1) % 100));
      check($sformatf("sweep%0d_done", i), done_a, 1'b0);
    end
    check("sweep_tc_count", tc_seen, 1);

    // Limit 25: dut_a holds, dut_c counts through
    lim_a = 8'h25;
    lim_c = 8'h25;
    en    = 1'b0;
    clr   = 1'b1;
    step();
    check("lim25_clr_q", q_a, 8'h00);
    clr = 1'b0;
    en  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      check($sformatf("lim25_q%0d", i),     q_a,    to_bcd((i < 25) ? i : 25));
      check($sformatf("lim25_done%0d", i),  done_a, (i >= 25));
      check($sformatf("lim25_qc%0d", i),    q_c,    to_bcd(i));
      check($sformatf("lim25_donec%0d", i), done_c, (i == 25));
    end
    check("lim25_m7d", m7d_a, 8'hA4);
    check("lim25_m7u", m7u_a, 8'h92);
    check("cnt40_m7d_c", m7d_c, 8'h66);
    check("cnt40_m7u_c", m7u_c, 8'h3F);

    // Clr and En together at 47
    lim_a = 8'hFF;
    lim_c = 8'hFF;
    en    = 1'b0;
    clr   = 1'b1;
    step();
    clr = 1'b0;
    en  = 1'b1;
    repeat (47) step();
    check("q47", q_a, 8'h47);
    clr = 1'b1;
    step();
    check("clr_en_q", q_a, 8'h00);
    clr = 1'b0;
    step();
    check("after_clr_q", q_a, 8'h01);

    // MAX_TENS=5 wrap on dut_b
    en  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      en = 1'b1;
      #1;
      check($sformatf("mod60_%0d_tc", i), tc_b, (i == 59));
      step();
      check($sformatf("mod60_%0d_q", i), q_b, to_bcd((i + 1) % 60));
    end

    // Asynchronous reset mid-cycle at 13
    lim_a = 8'h13;
    en    = 1'b0;
    clr   = 1'b1;
    step();
    clr = 1'b0;
    en  = 1'b1;
    repeat (13) step();
    check("pre_rst_q",    q_a,    8'h13);
    check("pre_rst_done", done_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q",    q_a,    8'h00);
    check("async_rst_done", done_a, 1'b0);
    check("async_rst_tc",   tc_a,   1'b0);
    check("async_rst_m7u",  m7u_a,  8'hC0);
    check("async_rst_m7d",  m7d_a,  8'hC0);
    step();
    check("rst_held_q", q_a, 8'h00);
    rst_n = 1'b1;

    // Frozen at 10, then limit moved to 12
    lim_a = 8'h10;
    en    = 1'b0;
    clr   = 1'b1;
    step();
    check("lim10_clr_done", done_a, 1'b0);
    clr = 1'b0;
    en  = 1'b1;
    repeat (12) step();
    check("lim10_q",    q_a,    8'h10);
    check("lim10_done", done_a, 1'b1);
    lim_a = 8'h12;
    step();
    check("relim_q0",    q_a,    8'h10);
    check("relim_done0", done_a, 1'b0);
    step();
    check("relim_q1",    q_a,    8'h11);
    check("relim_done1", done_a, 1'b0);
    step();
    check("relim_q2",    q_a,    8'h12);
    check("relim_done2", done_a, 1'b1);
    step();
    check("relim_q3",    q_a,    8'h12);
    check("relim_done3", done_a, 1'b1);

    en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
